// File: rtl/control_sequencer_pkg.sv
// Purpose: shared opcodes, T-state encoding and per-opcode last-step table for the CPU control unit.
// Latency: constants and a pure function only, with no storage.
// Backpressure: none.
package cpu_ctrl_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4,
        T5 = 3'd5
    } tstate_e;

    // Last T-state that does useful work for each opcode. Undefined
    // opcodes (0x9..0xD) behave as NOP, so they finish with the fetch.
    function automatic tstate_e last_step_of(input logic [3:0] op);
        tstate_e t;
        case (op)
            OP_LDA, OP_STA:                                 t = T4;
            OP_ADD, OP_SUB:                                 t = T5;
            OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT:   t = T3;
            default:                                        t = T2;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/control_sequencer_step_counter.sv
// Purpose: T-state counter plus sticky halt flag for the control sequencer.
// Latency: step and halted update on the posedge after the inputs are presented.
// Backpressure: none; a set halted flag freezes the counter until reset.
//
// Ports: clk, rst_n (synchronous, active-low); last_step = final T-state of
// the current opcode; halt_req = HLT is executing in T3; step/halted = state.
module step_counter
    import cpu_ctrl_pkg::*;
#(
    parameter bit EARLY_END = 1'b1,
    parameter int NUM_STEPS = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  tstate_e    last_step,
    input  logic       halt_req,
    output logic [2:0] step,
    output logic       halted
);

    tstate_e state_q, state_d;
    logic    halted_q, halted_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= T0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        halted_d = halted_q;
        if (halted_q) begin
            // frozen until reset
        end else if (halt_req) begin
            // HLT stays parked in T3 once stopped
            halted_d = 1'b1;
        end else if (EARLY_END && (state_q == last_step)) begin
            state_d = T0;
        end else if (state_q == tstate_e'(3'(NUM_STEPS - 1))) begin
            state_d = T0;
        end else begin
            state_d = tstate_e'(state_q + 3'd1);
        end
    end

    assign step   = state_q;
    assign halted = halted_q;

endmodule

// File: rtl/control_sequencer.sv
// Purpose: decodes T-state and opcode into the active-low bus strobes of the 8-bit CPU.
// Latency: strobes are combinational from step/opcode/flags; the step advances once per clk.
// Backpressure: none; halt freezes the sequencer with all strobes inactive until rst_n.
//
// Ports: clk, rst_n (synchronous, active-low); opcode = IR upper nibble;
// carry_flag/zero_flag = registered flags; pc_inc, adder_sub, halt active-high;
// every n_* strobe is active-low; step = current T-state for debug.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter bit EARLY_END = 1'b1,
    parameter int NUM_STEPS = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] opcode,
    input  logic       carry_flag,
    input  logic       zero_flag,
    output logic       pc_inc,
    output logic       n_pc_out,
    output logic       n_pc_load,
    output logic       n_mar_load,
    output logic       n_ram_out,
    output logic       n_ram_in,
    output logic       n_ir_load,
    output logic       n_ir_out,
    output logic       n_a_load,
    output logic       n_a_out,
    output logic       n_b_load,
    output logic       n_adder_out,
    output logic       adder_sub,
    output logic       n_flags_load,
    output logic       n_out_load,
    output logic       halt,
    output logic [2:0] step
);

    logic    halted;
    logic    halt_t3;
    logic    active;
    tstate_e last_step;

    // active-high internal strobes, gated and inverted at the ports
    logic pc_inc_s, pc_out_s, pc_load_s, mar_load_s, ram_out_s, ram_in_s;
    logic ir_load_s, ir_out_s, a_load_s, a_out_s, b_load_s, adder_out_s;
    logic sub_s, flags_load_s, out_load_s;

    assign last_step = last_step_of(opcode);

    step_counter #(
        .EARLY_END (EARLY_END),
        .NUM_STEPS (NUM_STEPS)
    ) u_step_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .last_step (last_step),
        .halt_req  (halt_t3),
        .step      (step),
        .halted    (halted)
    );

    always_comb begin
        pc_inc_s     = 1'b0;
        pc_out_s     = 1'b0;
        pc_load_s    = 1'b0;
        mar_load_s   = 1'b0;
        ram_out_s    = 1'b0;
        ram_in_s     = 1'b0;
        ir_load_s    = 1'b0;
        ir_out_s     = 1'b0;
        a_load_s     = 1'b0;
        a_out_s      = 1'b0;
        b_load_s     = 1'b0;
        adder_out_s  = 1'b0;
        sub_s        = 1'b0;
        flags_load_s = 1'b0;
        out_load_s   = 1'b0;
        halt_t3      = 1'b0;
        case (step)
            T0: begin
                pc_out_s   = 1'b1;
                mar_load_s = 1'b1;
            end
            T1: pc_inc_s = 1'b1;
            T2: begin
                ram_out_s = 1'b1;
                ir_load_s = 1'b1;
            end
            T3: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        ir_out_s   = 1'b1;
                        mar_load_s = 1'b1;
                    end
                    OP_LDI: begin
                        ir_out_s = 1'b1;
                        a_load_s = 1'b1;
                    end
                    OP_JMP: begin
                        ir_out_s  = 1'b1;
                        pc_load_s = 1'b1;
                    end
                    // conditional jumps leave the bus idle when not taken
                    OP_JC: begin
                        ir_out_s  = carry_flag;
                        pc_load_s = carry_flag;
                    end
                    OP_JZ: begin
                        ir_out_s  = zero_flag;
                        pc_load_s = zero_flag;
                    end
                    OP_OUT: begin
                        a_out_s    = 1'b1;
                        out_load_s = 1'b1;
                    end
                    OP_HLT:  halt_t3 = ~halted;
                    default: ;
                endcase
            end
            T4: begin
                case (opcode)
                    OP_LDA: begin
                        ram_out_s = 1'b1;
                        a_load_s  = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        ram_out_s = 1'b1;
                        b_load_s  = 1'b1;
                        sub_s     = (opcode == OP_SUB);
                    end
                    OP_STA: begin
                        a_out_s  = 1'b1;
                        ram_in_s = 1'b1;
                    end
                    default: ;
                endcase
            end
            T5: begin
                if (opcode == OP_ADD || opcode == OP_SUB) begin
                    adder_out_s  = 1'b1;
                    a_load_s     = 1'b1;
                    flags_load_s = 1'b1;
                    sub_s        = (opcode == OP_SUB);
                end
            end
            default: ;
        endcase
    end

    // reset and the halted state both force every strobe inactive
    assign active = rst_n & ~halted;

    assign pc_inc       = pc_inc_s & active;
    assign n_pc_out     = ~(pc_out_s & active);
    assign n_pc_load    = ~(pc_load_s & active);
    assign n_mar_load   = ~(mar_load_s & active);
    assign n_ram_out    = ~(ram_out_s & active);
    assign n_ram_in     = ~(ram_in_s & active);
    assign n_ir_load    = ~(ir_load_s & active);
    assign n_ir_out     = ~(ir_out_s & active);
    assign n_a_load     = ~(a_load_s & active);
    assign n_a_out      = ~(a_out_s & active);
    assign n_b_load     = ~(b_load_s & active);
    assign n_adder_out  = ~(adder_out_s & active);
    assign adder_sub    = sub_s & active;
    assign n_flags_load = ~(flags_load_s & active);
    assign n_out_load   = ~(out_load_s & active);
    assign halt         = rst_n & (halted | halt_t3);

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] opcode;
    logic       carry_flag;
    logic       zero_flag;

    int checks = 0;
    int fails  = 0;

    // Strobe vector, active-high, one bit per control line.
    localparam logic [15:0] M_PC_INC   = 16'h8000;
    localparam logic [15:0] M_PC_OUT   = 16'h4000;
    localparam logic [15:0] M_PC_LOAD  = 16'h2000;
    localparam logic [15:0] M_MAR      = 16'h1000;
    localparam logic [15:0] M_RAM_OUT  = 16'h0800;
    localparam logic [15:0] M_RAM_IN   = 16'h0400;
    localparam logic [15:0] M_IR_LOAD  = 16'h0200;
    localparam logic [15:0] M_IR_OUT   = 16'h0100;
    localparam logic [15:0] M_A_LOAD   = 16'h0080;
    localparam logic [15:0] M_A_OUT    = 16'h0040;
    localparam logic [15:0] M_B_LOAD   = 16'h0020;
    localparam logic [15:0] M_ADD_OUT  = 16'h0010;
    localparam logic [15:0] M_SUB      = 16'h0008;
    localparam logic [15:0] M_FLAGS    = 16'h0004;
    localparam logic [15:0] M_OUT      = 16'h0002;
    localparam logic [15:0] M_HALT     = 16'h0001;

    // DUT with early termination (dut1) and without (dut0), sharing inputs
    logic       pc_inc1, n_pc_out1, n_pc_load1, n_mar_load1, n_ram_out1, n_ram_in1, n_ir_load1, n_ir_out1;
    logic       n_a_load1, n_a_out1, n_b_load1, n_adder_out1, adder_sub1, n_flags_load1, n_out_load1, halt1;
    logic [2:0] step1;
    logic       pc_inc0, n_pc_out0, n_pc_load0, n_mar_load0, n_ram_out0, n_ram_in0, n_ir_load0, n_ir_out0;
    logic       n_a_load0, n_a_out0, n_b_load0, n_adder_out0, adder_sub0, n_flags_load0, n_out_load0, halt0;
    logic [2:0] step0;

    control_sequencer #(.EARLY_END(1'b1), .NUM_STEPS(6)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .carry_flag(carry_flag), .zero_flag(zero_flag),
        .pc_inc(pc_inc1), .n_pc_out(n_pc_out1), .n_pc_load(n_pc_load1), .n_mar_load(n_mar_load1),
        .n_ram_out(n_ram_out1), .n_ram_in(n_ram_in1), .n_ir_load(n_ir_load1), .n_ir_out(n_ir_out1),
        .n_a_load(n_a_load1), .n_a_out(n_a_out1), .n_b_load(n_b_load1), .n_adder_out(n_adder_out1),
        .adder_sub(adder_sub1), .n_flags_load(n_flags_load1), .n_out_load(n_out_load1),
        .halt(halt1), .step(step1)
    );

    control_sequencer #(.EARLY_END(1'b0), .NUM_STEPS(6)) dut_full (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .carry_flag(carry_flag), .zero_flag(zero_flag),
        .pc_inc(pc_inc0), .n_pc_out(n_pc_out0), .n_pc_load(n_pc_load0), .n_mar_load(n_mar_load0),
        .n_ram_out(n_ram_out0), .n_ram_in(n_ram_in0), .n_ir_load(n_ir_load0), .n_ir_out(n_ir_out0),
        .n_a_load(n_a_load0), .n_a_out(n_a_out0), .n_b_load(n_b_load0), .n_adder_out(n_adder_out0),
        .adder_sub(adder_sub0), .n_flags_load(n_flags_load0), .n_out_load(n_out_load0),
        .halt(halt0), .step(step0)
    );

    wire [15:0] a1 = {pc_inc1, ~n_pc_out1, ~n_pc_load1, ~n_mar_load1, ~n_ram_out1, ~n_ram_in1,
                      ~n_ir_load1, ~n_ir_out1, ~n_a_load1, ~n_a_out1, ~n_b_load1, ~n_adder_out1,
                      adder_sub1, ~n_flags_load1, ~n_out_load1, halt1};
    wire [15:0] a0 = {pc_inc0, ~n_pc_out0, ~n_pc_load0, ~n_mar_load0, ~n_ram_out0, ~n_ram_in0,
                      ~n_ir_load0, ~n_ir_out0, ~n_a_load0, ~n_a_out0, ~n_b_load0, ~n_adder_out0,
                      adder_sub0, ~n_flags_load0, ~n_out_load0, halt0};
    wire [4:0]  drv1 = {~n_pc_out1, ~n_ram_out1, ~n_ir_out1, ~n_a_out1, ~n_adder_out1};
    wire [4:0]  drv0 = {~n_pc_out0, ~n_ram_out0, ~n_ir_out0, ~n_a_out0, ~n_adder_out0};

    always #5 clk = ~clk;

    // Reference model: micro-operation table by opcode and T-state, plus
    // abstract step/halted state for each DUT variant.
    logic [15:0] utab [16][6];
    int          last_tbl [16] = '{2, 4, 5, 5, 4, 3, 3, 3, 3, 2, 2, 2, 2, 2, 3, 3};
    int          m1_step, m0_step;
    bit          m1_halt, m0_halt;
    logic [15:0] e1, e0;

    task automatic build_table();
        for (int op = 0; op < 16; op++) begin
            for (int t = 0; t < 6; t++) utab[op][t] = 16'h0;
            utab[op][0] = M_PC_OUT | M_MAR;
            utab[op][1] = M_PC_INC;
            utab[op][2] = M_RAM_OUT | M_IR_LOAD;
        end
        utab[1][3]  = M_IR_OUT | M_MAR;   utab[1][4] = M_RAM_OUT | M_A_LOAD;
        utab[2][3]  = M_IR_OUT | M_MAR;   utab[2][4] = M_RAM_OUT | M_B_LOAD;
        utab[2][5]  = M_ADD_OUT | M_A_LOAD | M_FLAGS;
        utab[3][3]  = M_IR_OUT | M_MAR;   utab[3][4] = M_RAM_OUT | M_B_LOAD | M_SUB;
        utab[3][5]  = M_ADD_OUT | M_A_LOAD | M_FLAGS | M_SUB;
        utab[4][3]  = M_IR_OUT | M_MAR;   utab[4][4] = M_A_OUT | M_RAM_IN;
        utab[5][3]  = M_IR_OUT | M_A_LOAD;
        utab[6][3]  = M_IR_OUT | M_PC_LOAD;
        utab[7][3]  = M_IR_OUT | M_PC_LOAD;
        utab[8][3]  = M_IR_OUT | M_PC_LOAD;
        utab[14][3] = M_A_OUT | M_OUT;
        utab[15][3] = M_HALT;
    endtask

    function automatic logic [15:0] exp_vec(input int st, input logic [3:0] op, input logic c,
                                            input logic z, input bit hl, input logic rs);
        if (!rs) return 16'h0;
        if (hl) return M_HALT;
        if (st > 5) return 16'hxxxx;
        if (st == 3 && op == 4'h7 && !c) return 16'h0;
        if (st == 3 && op == 4'h8 && !z) return 16'h0;
        return utab[op][st];
    endfunction

    task automatic model_next(inout int s, inout bit h, input bit ee);
        if (!rst_n) begin
            s = 0; h = 0;
        end else if (h) begin
        end else if (s == 3 && opcode == 4'hF) begin
            h = 1;
        end else if (ee && s == last_tbl[opcode]) begin
            s = 0;
        end else begin
            s = (s + 1) % 6;
        end
    endtask

    // Advance one clock edge; model updates from the inputs present at that edge.
    task automatic step_clk();
        int  s1 = m1_step, s0 = m0_step;
        bit  h1 = m1_halt, h0 = m0_halt;
        model_next(s1, h1, 1'b1);
        model_next(s0, h0, 1'b0);
        @(posedge clk);
        #1;
        m1_step = s1; m1_halt = h1;
        m0_step = s0; m0_halt = h0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step_clk();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; opcode = 4'h2; carry_flag = 1'b1; zero_flag = 1'b1;
        step_clk();
        step_clk();
        #1;
        checks++; if (a1 !== 16'h0) begin fails++; $display("FAIL reset_vec1 act=%h exp=0000", a1); end
        checks++; if (a0 !== 16'h0) begin fails++; $display("FAIL reset_vec0 act=%h exp=0000", a0); end
        checks++; if (step1 !== 3'd0) begin fails++; $display("FAIL reset_step1 act=%0d exp=0", step1); end
        checks++; if (step0 !== 3'd0) begin fails++; $display("FAIL reset_step0 act=%0d exp=0", step0); end
        rst_n = 1'b1;
    endtask

    task automatic test_fetch_nop();
        int seq [6] = '{0, 1, 2, 0, 1, 2};
        do_reset();
        opcode = 4'h0; carry_flag = 1'b0; zero_flag = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            e1 = exp_vec(m1_step, opcode, carry_flag, zero_flag, m1_halt, rst_n);
            checks++; if (step1 !== 3'(seq[i])) begin fails++; $display("FAIL nop_step i=%0d act=%0d exp=%0d", i, step1, seq[i]); end
            checks++; if (a1 !== e1) begin fails++; $display("FAIL nop_vec i=%0d act=%h exp=%h", i, a1, e1); end
            step_clk();
        end
    endtask

    task automatic test_sub();
        do_reset();
        opcode = 4'h3;
        for (int i = 0; i < 7; i++) begin
            #1;
            e1 = exp_vec(m1_step, opcode, carry_flag, zero_flag, m1_halt, rst_n);
            checks++; if (step1 !== 3'(m1_step)) begin fails++; $display("FAIL sub_step i=%0d act=%0d exp=%0d", i, step1, m1_step); end
            checks++; if (a1 !== e1) begin fails++; $display("FAIL sub_vec i=%0d act=%h exp=%h", i, a1, e1); end
            if (i == 5) begin
                checks++; if (adder_sub1 !== 1'b1) begin fails++; $display("FAIL sub_t5_adder_sub act=%b exp=1", adder_sub1); end
            end
            step_clk();
        end
        // seven cycles of a 6-step SUB: back at T1
        checks++; if (step1 !== 3'd1) begin fails++; $display("FAIL sub_wrap act=%0d exp=1", step1); end
    endtask

    task automatic test_jc();
        do_reset();
        opcode = 4'h7;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) begin
                // flag only matters in T3; toggle it during fetch
                carry_flag = (i == 3) ? k[0] : $urandom_range(0, 1);
                #1;
                e1 = exp_vec(m1_step, opcode, carry_flag, zero_flag, m1_halt, rst_n);
                checks++; if (a1 !== e1) begin fails++; $display("FAIL jc_vec k=%0d i=%0d act=%h exp=%h", k, i, a1, e1); end
                if (i == 3) begin
                    checks++; if (n_pc_load1 !== ~k[0]) begin fails++; $display("FAIL jc_pc_load k=%0d act=%b exp=%b", k, n_pc_load1, ~k[0]); end
                end
                step_clk();
            end
            checks++; if (step1 !== 3'd0) begin fails++; $display("FAIL jc_return k=%0d act=%0d exp=0", k, step1); end
        end
    endtask

    task automatic test_halt();
        do_reset();
        opcode = 4'hF;
        for (int i = 0; i < 24; i++) begin
            if (i > 3) begin
                opcode = 4'($urandom_range(0, 15));
                carry_flag = $urandom_range(0, 1);
                zero_flag = $urandom_range(0, 1);
            end
            #1;
            e1 = exp_vec(m1_step, opcode, carry_flag, zero_flag, m1_halt, rst_n);
            e0 = exp_vec(m0_step, opcode, carry_flag, zero_flag, m0_halt, rst_n);
            checks++; if (a1 !== e1) begin fails++; $display("FAIL halt_vec1 i=%0d act=%h exp=%h", i, a1, e1); end
            checks++; if (a0 !== e0) begin fails++; $display("FAIL halt_vec0 i=%0d act=%h exp=%h", i, a0, e0); end
            if (i >= 3) begin
                checks++; if (halt1 !== 1'b1) begin fails++; $display("FAIL halt_sticky i=%0d act=%b exp=1", i, halt1); end
                checks++; if (step1 !== 3'd3) begin fails++; $display("FAIL halt_step i=%0d act=%0d exp=3", i, step1); end
            end
            step_clk();
        end
        rst_n = 1'b0;
        step_clk();
        rst_n = 1'b1;
        #1;
        checks++; if (step1 !== 3'd0) begin fails++; $display("FAIL halt_clear_step act=%0d exp=0", step1); end
        checks++; if (halt1 !== 1'b0) begin fails++; $display("FAIL halt_clear act=%b exp=0", halt1); end
    endtask

    task automatic test_no_early_end();
        int seq [7] = '{0, 1, 2, 3, 4, 5, 0};
        do_reset();
        opcode = 4'h5;
        for (int i = 0; i < 7; i++) begin
            #1;
            e0 = exp_vec(m0_step, opcode, carry_flag, zero_flag, m0_halt, rst_n);
            checks++; if (step0 !== 3'(seq[i])) begin fails++; $display("FAIL full_step i=%0d act=%0d exp=%0d", i, step0, seq[i]); end
            checks++; if (a0 !== e0) begin fails++; $display("FAIL full_vec i=%0d act=%h exp=%h", i, a0, e0); end
            step_clk();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        opcode = 4'h1;
        repeat (4) step_clk();
        #1;
        checks++; if (step1 !== 3'd4) begin fails++; $display("FAIL mid_at_t4 act=%0d exp=4", step1); end
        rst_n = 1'b0;
        #1;
        checks++; if (a1 !== 16'h0) begin fails++; $display("FAIL mid_gated act=%h exp=0000", a1); end
        step_clk();
        rst_n = 1'b1;
        #1;
        checks++; if (step1 !== 3'd0) begin fails++; $display("FAIL mid_restart act=%0d exp=0", step1); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (m1_step == 0) opcode = 4'($urandom_range(0, 14));
            carry_flag = $urandom_range(0, 1);
            zero_flag = $urandom_range(0, 1);
            rst_n = ($urandom_range(0, 49) != 0);
            #1;
            e1 = exp_vec(m1_step, opcode, carry_flag, zero_flag, m1_halt, rst_n);
            e0 = exp_vec(m0_step, opcode, carry_flag, zero_flag, m0_halt, rst_n);
            checks++; if (a1 !== e1) begin fails++; $display("FAIL rnd_vec1 i=%0d op=%h act=%h exp=%h", i, opcode, a1, e1); end
            checks++; if (a0 !== e0) begin fails++; $display("FAIL rnd_vec0 i=%0d op=%h act=%h exp=%h", i, opcode, a0, e0); end
            checks++; if (step1 !== 3'(m1_step)) begin fails++; $display("FAIL rnd_step1 i=%0d act=%0d exp=%0d", i, step1, m1_step); end
            checks++; if (step0 !== 3'(m0_step)) begin fails++; $display("FAIL rnd_step0 i=%0d act=%0d exp=%0d", i, step0, m0_step); end
            checks++; if ($countones(drv1) > 1) begin fails++; $display("FAIL rnd_bus1 i=%0d drivers=%b exp=at most one", i, drv1); end
            checks++; if ($countones(drv0) > 1) begin fails++; $display("FAIL rnd_bus0 i=%0d drivers=%b exp=at most one", i, drv0); end
            step_clk();
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; opcode = 4'h0; carry_flag = 1'b0; zero_flag = 1'b0;
        m1_step = 0; m0_step = 0; m1_halt = 0; m0_halt = 0;
        build_table();
        test_reset();
        test_fetch_nop();
        test_sub();
        test_jc();
        test_halt();
        test_no_early_end();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
